// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector with a runtime-loadable pattern. It tracks the
//   length of the longest pattern prefix that ends at the newest accepted bit.
//   It emits a registered one-cycle pulse on every complete match and counts
//   the matches in a saturating counter.
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high; restores PAT_INIT, clears all state
//   in / in_valid  serial data bit, accepted only while in_valid is high
//   cfg_load       load cfg_pattern into the pattern register, restart matching
//   cfg_pattern    new pattern, bit PAT_LEN-1 is matched first
//   cnt_clr        clear match_count (wins over a same-cycle increment)
//   out            one-cycle match pulse, registered
//   match_count    saturating match count
//   present_state  current matched-prefix length (0..PAT_LEN-1)
module seq_detector_param #(
    parameter int unsigned        PAT_LEN  = 4,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 4'b1011,
    parameter bit                 OVERLAP  = 1'b1,
    parameter int unsigned        CNT_W    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in,
    input  logic                       in_valid,
    input  logic                       cfg_load,
    input  logic [PAT_LEN-1:0]         cfg_pattern,
    input  logic                       cnt_clr,
    output logic                       out,
    output logic [CNT_W-1:0]           match_count,
    output logic [$clog2(PAT_LEN)-1:0] present_state
);

    localparam int unsigned   SW   = $clog2(PAT_LEN);
    localparam logic [SW-1:0] LAST = SW'(PAT_LEN - 1);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN must be in 2..16");
    end

    logic [PAT_LEN-1:0] pat_q, pat_nx;
    logic [SW-1:0]      state_q, state_nx;
    logic               out_q, out_nx;
    logic [CNT_W-1:0]   cnt_q, cnt_nx;

    logic [31:0]        cur_len;
    logic [31:0]        best_len;
    logic [31:0]        pos;
    logic               ok;
    logic               cand_bit;
    logic               hit;

    // Pattern bit i in match order (i = 0 is the first bit compared).
    function automatic logic pat_bit(input logic [PAT_LEN-1:0] p, input int unsigned i);
        logic [PAT_LEN-1:0] sh;
        sh = p >> (PAT_LEN - 1 - i);
        return sh[0];
    endfunction

    // Fallback: the longest prefix of length k (1..PAT_LEN-1) that is a suffix of
    // the current matched prefix extended by 'in'. The same search covers a
    // plain advance (k = cur_len+1), a mismatch fallback, and the border taken
    // after a full match. It always uses the live pattern register.
    always_comb begin
        cur_len  = 32'(state_q);
        best_len = '0;
        pos      = '0;
        ok       = 1'b0;
        cand_bit = 1'b0;
        for (int unsigned k = 1; k < PAT_LEN; k++) begin
            ok = (k <= cur_len + 1);
            for (int unsigned j = 0; j < PAT_LEN - 1; j++) begin
                if (ok && (j < k)) begin
                    pos      = cur_len + 1 - k + j;
                    cand_bit = (pos == cur_len) ? in : pat_bit(pat_q, pos);
                    if (cand_bit != pat_bit(pat_q, j)) begin
                        ok = 1'b0;
                    end
                end
            end
            if (ok) begin
                best_len = k;
            end
        end
    end

    assign hit = (state_q == LAST) && (in == pat_q[0]);

    always_comb begin
        pat_nx   = pat_q;
        state_nx = state_q;
        out_nx   = 1'b0;
        cnt_nx   = cnt_q;

        if (cfg_load) begin
            pat_nx   = cfg_pattern;
            state_nx = '0;
        end else if (in_valid) begin
            out_nx = hit;
            if (hit && !OVERLAP) begin
                state_nx = '0;
            end else begin
                state_nx = SW'(best_len);
            end
            if (hit && (cnt_q != '1)) begin
                cnt_nx = cnt_q + CNT_W'(1);
            end
        end

        if (cnt_clr) begin
            cnt_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pat_q   <= PAT_INIT;
            state_q <= '0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pat_q   <= pat_nx;
            state_q <= state_nx;
            out_q   <= out_nx;
            cnt_q   <= cnt_nx;
        end
    end

    assign out           = out_q;
    assign match_count   = cnt_q;
    assign present_state = state_q;

endmodule

// File: doc/seq_detector_param.md
SEQ_DETECTOR_PARAM -- requirements
Module: seq_detector_param

Interface
REQ-001 SHALL have parameter PAT_LEN, default 4: pattern length in bits; legal range 2..16.
REQ-002 SHALL have parameter PAT_INIT, default 4'b1011: pattern loaded at reset, PAT_LEN bits wide.
REQ-003 SHALL have parameter OVERLAP, default 1: 1 = overlapping matches allowed, 0 = non-overlapping.
REQ-004 SHALL have parameter CNT_W, default 8: match counter width.
REQ-005 SHALL have ports clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have ports reset, input, 1 bit: reset is synchronous and active-high.
REQ-007 SHALL have ports in, input, 1 bit: serial data bit.
REQ-008 SHALL have ports in_valid, input, 1 bit: in is sampled only when 1.
REQ-009 SHALL have ports cfg_load, input, 1 bit: load cfg_pattern into the pattern register.
REQ-010 SHALL have ports cfg_pattern, input, PAT_LEN bits: new pattern; bit PAT_LEN-1 is matched first.
REQ-011 SHALL have ports cnt_clr, input, 1 bit: clear match_count.
REQ-012 SHALL have ports out, output, 1 bit: registered one-cycle match pulse.
REQ-013 SHALL have ports match_count, output, CNT_W bits: saturating count of matches.
REQ-014 SHALL have ports present_state, output, $clog2(PAT_LEN) bits: current matched-prefix length.

Function
REQ-015 State SHALL equal the length (0..PAT_LEN-1) of the longest prefix of the pattern that is a suffix of the accepted bits since the last reset, load or non-overlapping match.
REQ-016 Pattern order SHALL be MSB first: the first accepted bit is compared with pattern[PAT_LEN-1].
REQ-017 With in_valid=1 and state s: if in equals pattern bit (PAT_LEN-1-s) and s<PAT_LEN-1, next state SHALL be s+1.
REQ-018 On a mismatch, next state SHALL be the longest prefix that is a suffix of (matched prefix followed by in), found by KMP-style fallback and not forced to 0; this SHALL be evaluated against the current runtime pattern register.
REQ-019 On a full match (state PAT_LEN-1 and matching bit), out SHALL be 1 for exactly the next cycle.
REQ-020 After a match, next state SHALL be the longest proper border of the pattern if OVERLAP=1, or 0 if OVERLAP=0.
REQ-021 Match latency SHALL be one clock: out rises at the edge that samples the final pattern bit and is observable until the following edge.
REQ-022 With in_valid=0, state, pattern register and match_count SHALL hold, and out SHALL be 0 on the next cycle.
REQ-023 match_count SHALL increment by 1 per match and saturate at 2^CNT_W-1, with no wrap.
REQ-024 When cnt_clr=1, match_count SHALL become 0; if a match occurs in the same cycle, cnt_clr wins and the count is 0, but out still pulses.
REQ-025 When cfg_load=1, the pattern register SHALL take cfg_pattern, state SHALL become 0, and out SHALL be 0 next cycle; an in_valid bit in the same cycle is discarded; match_count is unchanged.
REQ-026 A pattern of all zeros or all ones SHALL be legal; its border is PAT_LEN-1 with OVERLAP=1.
REQ-027 Priority SHALL be reset > cfg_load > in_valid processing; cnt_clr is independent of cfg_load.

Reset
REQ-028 When reset=1 at a rising edge: state SHALL be 0, out 0, match_count 0, and the pattern register PAT_INIT, regardless of other inputs.
REQ-029 Reset asserted mid-pattern SHALL discard the partial match; no match SHALL complete using bits accepted before reset.
REQ-030 There SHALL be no asynchronous behaviour; outputs SHALL change only on clk rising edges.

Verification
REQ-031 Defaults, OVERLAP=1, in_valid=1, stream 1,0,1,1,0,1,1 -> out pulses after bits 4 and 7; match_count=2; state after bit 4 is 1.
REQ-032 Same stream with OVERLAP=0 -> a single pulse after bit 4; match_count=1.
REQ-033 cfg_load with 4'b1101, then stream 1,1,1,0,1 -> states 1,2,2,3, then a pulse after bit 5 (fallback from 3 ones to state 2).
REQ-034 Defaults, stream 1,0,1 then in_valid=0 for 3 cycles, then 1 -> state holds at 3 during the stall, and out pulses once after the final 1.
REQ-035 Defaults, stream 1,0,1, then reset for one cycle, then 1 -> no pulse and state=1; then 0,1,1 -> pulse.
REQ-036 CNT_W=2, 5 matches -> match_count reads 1,2,3,3,3; cnt_clr together with the 6th match -> match_count=0 and out=1.
